// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, flag bit positions and the
// next-PC source selector used by the fetch-side branch unit.
package cpu_pkg;

  localparam logic [3:0] OP_BR    = 4'h9;
  localparam logic [3:0] OP_BRC   = 4'hA;
  localparam logic [3:0] OP_BRSUB = 4'hB;
  localparam logic [3:0] OP_RET   = 4'hC;

  localparam int ZN_Z = 1;
  localparam int ZN_N = 0;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_TGT = 2'd1,
    NPC_RAS = 2'd2
  } npc_sel_e;

endpackage

// File: rtl/pc_branch_unit_if.sv
// Decode-side bus of the branch unit: resolving instruction in, PC and RAS status out.
interface pc_branch_unit_if #(parameter int AW = 8);

    logic          en;
    logic [3:0]    op;
    logic          brx;
    logic [1:0]    zn;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic          is_branch;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    modport master (
        output en, op, brx, zn, target,
        input  pc, is_branch, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  en, op, brx, zn, target,
        output pc, is_branch, ras_empty, ras_full, ras_ovf, ras_unf
    );

endinterface

// File: rtl/ras_stack.sv
// Return-address stack storage and pointers. Build option RAS_WRAP_EN turns a
// push-while-full into an overwrite of the oldest entry instead of a drop.
module ras_stack #(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] wdata,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
`ifdef RAS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [AW-1:0] mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_m1;
    logic [CW-1:0] cnt;
    logic          wr;

    // ptr is the next write slot; once full it also points at the oldest entry
    assign ptr_m1 = ptr - PW'(1);
    assign top    = mem[ptr_m1];
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(RAS_DEPTH));
    assign wr     = push && (!full || WRAP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[ptr] <= wdata;
                ptr      <= ptr + PW'(1);
            end
            if (push && !full) cnt <= cnt + CW'(1);
            if (push && full)  ovf <= 1'b1;
            if (pop && !empty) begin
                ptr <= ptr_m1;
                cnt <= cnt - CW'(1);
            end
            if (pop && empty)  unf <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch-side PC with branch decode and a hardware return-address stack.
// Optional build macro RAS_WRAP_EN selects circular overwrite on RAS overflow.
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    pc_branch_unit_if.slave bus
);

    logic          cond;
    logic          taken;
    logic          ret;
    npc_sel_e      sel;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] ras_top;
    logic          ras_empty;

    // Decode is purely combinational so is_branch tracks inputs even while stalled
    always_comb begin
        cond   = bus.brx ? bus.zn[ZN_N] : bus.zn[ZN_Z];
        taken  = (bus.op == OP_BR) || (bus.op == OP_BRSUB) || ((bus.op == OP_BRC) && cond);
        ret    = (bus.op == OP_RET);
        pc_inc = pc_q + AW'(1);
        sel    = NPC_SEQ;
        if (taken)                 sel = NPC_TGT;
        else if (ret && !ras_empty) sel = NPC_RAS;
        case (sel)
            NPC_TGT: pc_nxt = bus.target;
            NPC_RAS: pc_nxt = ras_top;
            default: pc_nxt = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        pc_q <= '0;
        else if (bus.en) pc_q <= pc_nxt;
    end

    ras_stack #(.AW(AW), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.en && (bus.op == OP_BRSUB)),
        .pop   (bus.en && ret),
        .wdata (pc_inc),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (bus.ras_full),
        .ovf   (bus.ras_ovf),
        .unf   (bus.ras_unf)
    );

    assign bus.pc        = pc_q;
    assign bus.is_branch = taken || ret;
    assign bus.ras_empty = ras_empty;

endmodule
